div_share_ctrl: RTL and testbench

//   Scheduler that shares one multi-cycle unsigned divider between N requesters.
//   - Round-robin grant; captures the winner's dividend/divisor.
//   - Issues one start pulse to the divider, waits for done, and returns

---
 rtl/div_share_if.sv | 32 +++
 rtl/div_share_ctrl.sv | 171 +++++++++++++++++
 tb/tb_div_share_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_share_if.sv
// Bundle of client request/response lanes and the shared divider handshake.
// The controller uses the slave modport; clients plus divider use the master modport.
interface div_share_if #(
    parameter int W = 5,
    parameter int N = 2
);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_q;
    logic [W-1:0]   rsp_r;
    logic           rsp_err;
    logic [N-1:0]   rsp_ready;
    logic           div_start;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic           div_done;
    logic [W-1:0]   div_q;
    logic [W-1:0]   div_r;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, div_done, div_q, div_r,
        output req_ready, rsp_valid, rsp_q, rsp_r, rsp_err, div_start, div_a, div_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, div_done, div_q, div_r,
        input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_err, div_start, div_a, div_b
    );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin scheduler sharing one multi-cycle divider among N clients,
// with divide-by-zero bypass and a hung-divider timeout.
module div_share_ctrl #(
    parameter int W       = 5,
    parameter int N       = 2,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    div_share_if.slave bus
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  div_a_q, div_a_d;
    logic [W-1:0]  div_b_q, div_b_d;
    logic          div_start_q, div_start_d;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic [W-1:0]  rsp_q_q, rsp_q_d;
    logic [W-1:0]  rsp_r_q, rsp_r_d;
    logic          rsp_err_q, rsp_err_d;

    logic [GW:0]   sum_s;
    logic [GW:0]   cand_s;
    logic          hit_s;
    logic [GW-1:0] sel_s;
    logic          sel_found_s;
    logic [W-1:0]  sel_a_s;
    logic [W-1:0]  sel_b_s;
    logic [N-1:0]  req_ready_s;

    // Round-robin search starting at the client after the last one served
    always_comb begin
        sum_s       = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        sel_s       = last_grant_q;
        sel_found_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            sum_s       = {1'b0, last_grant_q} + (GW+1)'(k);
            cand_s      = (sum_s >= (GW+1)'(N)) ? (sum_s - (GW+1)'(N)) : sum_s;
            hit_s       = !sel_found_s && bus.req_valid[cand_s[GW-1:0]];
            sel_s       = hit_s ? cand_s[GW-1:0] : sel_s;
            sel_found_s = sel_found_s || hit_s;
        end
        sel_a_s = bus.req_a[int'(sel_s)*W +: W];
        sel_b_s = bus.req_b[int'(sel_s)*W +: W];
    end

    // FSM next state plus next values of every registered output
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        div_start_d  = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_q_d      = rsp_q_q;
        rsp_r_d      = rsp_r_q;
        rsp_err_d    = rsp_err_q;
        req_ready_s  = '0;
        case (state_q)
            S_IDLE: begin
                if (sel_found_s) begin
                    req_ready_s = N'(1) << sel_s;
                    gnt_d       = sel_s;
                    if (sel_b_s == '0) begin
                        // Zero divisor answered locally; divider never sees it
                        rsp_valid_d = N'(1) << sel_s;
                        rsp_q_d     = '1;
                        rsp_r_d     = sel_a_s;
                        rsp_err_d   = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        div_a_d     = sel_a_s;
                        div_b_d     = sel_b_s;
                        div_start_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (bus.div_done) begin
                    rsp_valid_d = N'(1) << gnt_q;
                    rsp_q_d     = bus.div_q;
                    rsp_r_d     = bus.div_r;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_valid_d = N'(1) << gnt_q;
                    rsp_q_d     = '0;
                    rsp_r_d     = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready[gnt_q]) begin
                    rsp_valid_d  = '0;
                    last_grant_d = gnt_q;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            last_grant_q <= GW'(N - 1);
            timer_q      <= '0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            div_start_q  <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_q_q      <= '0;
            rsp_r_q      <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            div_start_q  <= div_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_q_q      <= rsp_q_d;
            rsp_r_q      <= rsp_r_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_q     = rsp_q_q;
    assign bus.rsp_r     = rsp_r_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.div_start = div_start_q;
    assign bus.div_a     = div_a_q;
    assign bus.div_b     = div_b_q;
endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: the bench plays both clients and the divider.
module tb_div_share_ctrl;
    localparam int W       = 5;
    localparam int N       = 2;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    div_share_if #(.W(W), .N(N)) bus ();

    div_share_ctrl #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[c*W +: W] = a;
        bus.req_b[c*W +: W] = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
        bus.div_done = 1'b0; bus.div_q = '0; bus.div_r = '0;
        step(2);
        reset = 1'b0;
        #1;
        n_checks++; if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err} !== 13'd0) $display("FAIL reset_rsp: got %h exp 0", {bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err}); else n_pass++;
        n_checks++; if ({bus.div_start, bus.div_a, bus.div_b, bus.req_ready} !== 13'd0) $display("FAIL reset_div: got %h exp 0", {bus.div_start, bus.div_a, bus.div_b, bus.req_ready}); else n_pass++;
    endtask

    task automatic test_basic();
        int starts;
        starts = 0;
        set_op(0, 5'd7, 5'd5);
        bus.req_valid = 2'b01;
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) $display("FAIL basic_ready: got %b exp 01", bus.req_ready); else n_pass++;
        step();
        bus.req_valid = 2'b00;
        n_checks++; if ({bus.div_start, bus.div_a, bus.div_b} !== {1'b1, 5'd7, 5'd5}) $display("FAIL basic_issue: got %h exp %h", {bus.div_start, bus.div_a, bus.div_b}, {1'b1, 5'd7, 5'd5}); else n_pass++;
        for (int i = 0; i < 9; i++) begin
            step();
            if (bus.div_start) starts++;
        end
        n_checks++; if ({bus.div_a, bus.div_b, bus.rsp_valid} !== {5'd7, 5'd5, 2'b00}) $display("FAIL basic_hold: got %h exp %h", {bus.div_a, bus.div_b, bus.rsp_valid}, {5'd7, 5'd5, 2'b00}); else n_pass++;
        bus.div_done = 1'b1; bus.div_q = 5'd1; bus.div_r = 5'd2;
        step();
        bus.div_done = 1'b0; bus.div_q = 5'd0; bus.div_r = 5'd0;
        n_checks++; if (starts !== 0) $display("FAIL basic_single_start: got %0d extra exp 0", starts); else n_pass++;
        n_checks++; if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err} !== {2'b01, 5'd1, 5'd2, 1'b0}) $display("FAIL basic_rsp: got %h exp %h", {bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err}, {2'b01, 5'd1, 5'd2, 1'b0}); else n_pass++;
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = 2'b00;
        n_checks++; if (bus.rsp_valid !== 2'b00) $display("FAIL basic_drop: got %b exp 00", bus.rsp_valid); else n_pass++;
    endtask

    task automatic test_div_zero();
        set_op(1, 5'd9, 5'd0);
        bus.req_valid = 2'b10;
        #1;
        n_checks++; if (bus.req_ready !== 2'b10) $display("FAIL dz_ready: got %b exp 10", bus.req_ready); else n_pass++;
        step();
        bus.req_valid = 2'b00;
        n_checks++; if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err, bus.div_start} !== {2'b10, 5'd31, 5'd9, 1'b1, 1'b0}) $display("FAIL dz_rsp: got %h exp %h", {bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err, bus.div_start}, {2'b10, 5'd31, 5'd9, 1'b1, 1'b0}); else n_pass++;
        step();
        n_checks++; if ({bus.rsp_valid, bus.div_start} !== {2'b10, 1'b0}) $display("FAIL dz_hold: got %b exp 100", {bus.rsp_valid, bus.div_start}); else n_pass++;
        bus.rsp_ready = 2'b10;
        step();
        bus.rsp_ready = 2'b00;
        n_checks++; if (bus.rsp_valid !== 2'b00) $display("FAIL dz_drop: got %b exp 00", bus.rsp_valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0]   exp_g;
        logic [W-1:0] exp_a, exp_q, exp_r;
        set_op(0, 5'd20, 5'd3);
        set_op(1, 5'd17, 5'd4);
        bus.req_valid = 2'b11;
        for (int op = 0; op < 4; op++) begin
            exp_g = (op % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (op % 2 == 0) ? 5'd20 : 5'd17;
            exp_q = (op % 2 == 0) ? 5'd6 : 5'd4;
            exp_r = (op % 2 == 0) ? 5'd2 : 5'd1;
            #1;
            n_checks++; if (bus.req_ready !== exp_g) $display("FAIL rr_grant%0d: got %b exp %b", op, bus.req_ready, exp_g); else n_pass++;
            step();
            n_checks++; if ({bus.div_start, bus.div_a} !== {1'b1, exp_a}) $display("FAIL rr_issue%0d: got %h exp %h", op, {bus.div_start, bus.div_a}, {1'b1, exp_a}); else n_pass++;
            step();
            n_checks++; if ({bus.div_start, bus.req_ready} !== 3'b000) $display("FAIL rr_wait%0d: got %b exp 000", op, {bus.div_start, bus.req_ready}); else n_pass++;
            bus.div_done = 1'b1; bus.div_q = exp_q; bus.div_r = exp_r;
            step();
            bus.div_done = 1'b0;
            n_checks++; if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err} !== {exp_g, exp_q, exp_r, 1'b0}) $display("FAIL rr_rsp%0d: got %h exp %h", op, {bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err}, {exp_g, exp_q, exp_r, 1'b0}); else n_pass++;
            bus.rsp_ready = 2'b11;
            step();
            bus.rsp_ready = 2'b00;
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_timeout();
        int cyc;
        set_op(0, 5'd3, 5'd1);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        n_checks++; if (bus.div_start !== 1'b1) $display("FAIL to_start: got %b exp 1", bus.div_start); else n_pass++;
        cyc = 0;
        while (bus.rsp_valid === 2'b00 && cyc < 80) begin
            step();
            cyc++;
        end
        n_checks++; if (cyc !== 65) $display("FAIL to_latency: got %0d cycles exp 65", cyc); else n_pass++;
        n_checks++; if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err} !== {2'b01, 5'd0, 5'd0, 1'b1}) $display("FAIL to_rsp: got %h exp %h", {bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err}, {2'b01, 5'd0, 5'd0, 1'b1}); else n_pass++;
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = 2'b00;
        // done arriving in the last allowed wait cycle must win over the timeout
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        step(64);
        n_checks++; if (bus.rsp_valid !== 2'b00) $display("FAIL to_edge_early: got %b exp 00", bus.rsp_valid); else n_pass++;
        bus.div_done = 1'b1; bus.div_q = 5'd3; bus.div_r = 5'd0;
        step();
        bus.div_done = 1'b0;
        n_checks++; if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err} !== {2'b01, 5'd3, 5'd0, 1'b0}) $display("FAIL to_edge_done: got %h exp %h", {bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err}, {2'b01, 5'd3, 5'd0, 1'b0}); else n_pass++;
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        set_op(0, 5'd10, 5'd3);
        set_op(1, 5'd15, 5'd2);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b11;
        #1;
        n_checks++; if ({bus.div_start, bus.req_ready} !== 3'b100) $display("FAIL bp_issue: got %b exp 100", {bus.div_start, bus.req_ready}); else n_pass++;
        step();
        bus.div_done = 1'b1; bus.div_q = 5'd3; bus.div_r = 5'd1;
        step();
        bus.div_done = 1'b0; bus.div_q = 5'd0; bus.div_r = 5'd0;
        bus.rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err, bus.req_ready} !== {2'b01, 5'd3, 5'd1, 1'b0, 2'b00}) bad++;
            step();
        end
        n_checks++; if (bad !== 0) $display("FAIL bp_stable: got %0d bad cycles exp 0", bad); else n_pass++;
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = 2'b00;
        #1;
        n_checks++; if (bus.req_ready !== 2'b10) $display("FAIL bp_next_grant: got %b exp 10", bus.req_ready); else n_pass++;
        step();
        bus.req_valid = 2'b00;
        n_checks++; if ({bus.div_start, bus.div_a, bus.div_b} !== {1'b1, 5'd15, 5'd2}) $display("FAIL bp_issue1: got %h exp %h", {bus.div_start, bus.div_a, bus.div_b}, {1'b1, 5'd15, 5'd2}); else n_pass++;
        step();
        bus.div_done = 1'b1; bus.div_q = 5'd7; bus.div_r = 5'd1;
        step();
        bus.div_done = 1'b0;
        n_checks++; if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err} !== {2'b10, 5'd7, 5'd1, 1'b0}) $display("FAIL bp_rsp1: got %h exp %h", {bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err}, {2'b10, 5'd7, 5'd1, 1'b0}); else n_pass++;
        bus.rsp_ready = 2'b10;
        step();
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        // fast client-0 op so that the remembered last grant is 0
        set_op(0, 5'd4, 5'd0);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        n_checks++; if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err} !== {2'b01, 5'd31, 5'd4, 1'b1}) $display("FAIL rm_pre: got %h exp %h", {bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err}, {2'b01, 5'd31, 5'd4, 1'b1}); else n_pass++;
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = 2'b00;
        set_op(1, 5'd6, 5'd2);
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = 2'b00;
        step(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++; if ({bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err, bus.div_start, bus.div_a, bus.div_b, bus.req_ready} !== 26'd0) $display("FAIL rm_outputs: got %h exp 0", {bus.rsp_valid, bus.rsp_q, bus.rsp_r, bus.rsp_err, bus.div_start, bus.div_a, bus.div_b, bus.req_ready}); else n_pass++;
        bus.div_done = 1'b1; bus.div_q = 5'd3; bus.div_r = 5'd0;
        step();
        bus.div_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.rsp_valid !== 2'b00 || bus.div_start !== 1'b0) stray++;
            step();
        end
        n_checks++; if (stray !== 0) $display("FAIL rm_stray_rsp: got %0d cycles exp 0", stray); else n_pass++;
        bus.req_valid = 2'b11;
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) $display("FAIL rm_priority: got %b exp 01", bus.req_ready); else n_pass++;
        bus.req_valid = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_round_robin();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
